// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_pkg
//  Brief    : Shared widths, opcodes and types for the shared-ALU arbiter
//  Revision : 1.0  initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef OP_ADD
`define OP_ADD 4'd0
`endif
`ifndef OP_SUB
`define OP_SUB 4'd1
`endif
`ifndef OP_MUL
`define OP_MUL 4'd2
`endif
`ifndef OP_CMP
`define OP_CMP 4'd3
`endif
`ifndef ALU_ARB_LATENCY
`define ALU_ARB_LATENCY 2
`endif

package alu_arbiter_pkg;

    localparam int DATA_WIDTH      = `DATA_WIDTH;
    localparam int OPCODE_W        = 4;
    // Cycles from the accept edge to the response strobe.
    localparam int ALU_ARB_LATENCY = `ALU_ARB_LATENCY;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [OPCODE_W-1:0]   opcode_t;

    typedef enum logic [OPCODE_W-1:0] {
        ALU_ADD = `OP_ADD,
        ALU_SUB = `OP_SUB,
        ALU_MUL = `OP_MUL,
        ALU_CMP = `OP_CMP
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_alu
//  Brief    : Combinational unsigned ALU shared by all arbiter requesters.
//             ADD/SUB wrap, MUL keeps the low bits, CMP only drives the flag.
//  Revision : 1.0  initial release
// ============================================================================

module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [OPCODE_W-1:0]   i_opcode,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_cmp_flag
);

    // Opcode decode; unknown opcodes fall through to result 0, flag 0.
    always_comb begin
        o_result   = '0;
        o_cmp_flag = 1'b0;
        case (i_opcode)
            ALU_ADD: o_result   = i_operand_a + i_operand_b;
            ALU_SUB: o_result   = i_operand_a - i_operand_b;
            ALU_MUL: o_result   = i_operand_a * i_operand_b;
            ALU_CMP: o_cmp_flag = (i_operand_a < i_operand_b);
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Round-robin arbiter sharing one ALU among NUM_REQ requesters.
//             Valid/ready request side, two register stages, fixed-latency
//             tagged response. A requester may have only one op in flight.
//  Revision : 1.0  initial release
// ============================================================================

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [OPCODE_W*NUM_REQ-1:0]   req_opcode,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [REQ_ID_W-1:0]           resp_id,
    output logic [DATA_WIDTH-1:0]         resp_result,
    output logic                          resp_cmp,
    output logic                          busy
);

    // Contents of the first pipeline stage: who asked and what to compute.
    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        opcode_t             opcode;
        data_t               a;
        data_t               b;
    } s1_t;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic [REQ_ID_W-1:0] grant_id;
    logic                grant_found;
    logic                accept;
    logic [REQ_ID_W:0]   cand;

    opcode_t             sel_opcode;
    data_t               sel_a;
    data_t               sel_b;

    logic [NUM_REQ-1:0]  set_mask;
    logic [NUM_REQ-1:0]  clr_mask;

    logic [NUM_REQ-1:0]  pending_q,     pending_d;
    logic [REQ_ID_W-1:0] rr_ptr_q,      rr_ptr_d;
    logic                s1_valid_q,    s1_valid_d;
    s1_t                 s1_q,          s1_d;
    logic                resp_valid_q,  resp_valid_d;
    logic [REQ_ID_W-1:0] resp_id_q,     resp_id_d;
    data_t               resp_result_q, resp_result_d;
    logic                resp_cmp_q,    resp_cmp_d;

    data_t               alu_result;
    logic                alu_cmp;

    // A requester with an op in flight is not eligible until its response.
    assign eligible = req_valid & ~pending_q;

    // Round-robin pick: first eligible index starting at rr_ptr, with wrap.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (REQ_ID_W+1)'(k);
            if (cand >= (REQ_ID_W+1)'(NUM_REQ)) begin
                cand = cand - (REQ_ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && eligible[cand[REQ_ID_W-1:0]]) begin
                grant_found                  = 1'b1;
                grant_id                     = cand[REQ_ID_W-1:0];
                grant[cand[REQ_ID_W-1:0]]    = 1'b1;
            end
        end
    end

    // Ready is suppressed while reset is held so nothing looks accepted.
    assign req_ready = grant & {NUM_REQ{~reset}};
    assign accept    = grant_found & ~reset;

    // Route the granted requester's opcode and operands to stage 1.
    always_comb begin
        sel_opcode = '0;
        sel_a      = '0;
        sel_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_opcode = req_opcode[OPCODE_W*i +: OPCODE_W];
                sel_a      = req_a[DATA_WIDTH*i +: DATA_WIDTH];
                sel_b      = req_b[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // The single shared ALU evaluates whatever sits in stage 1.
    alu_arbiter_alu u_alu (
        .i_opcode    (s1_q.opcode),
        .i_operand_a (s1_q.a),
        .i_operand_b (s1_q.b),
        .o_result    (alu_result),
        .o_cmp_flag  (alu_cmp)
    );

    // Pending set on accept, cleared at the end of the owner's response cycle.
    always_comb begin
        set_mask = accept ? grant : '0;
        clr_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            clr_mask[i] = resp_valid_q && (resp_id_q == REQ_ID_W'(i));
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // Pointer moves past the winner; it holds on idle cycles.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (grant_id == REQ_ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_id + REQ_ID_W'(1);
            end
        end
    end

    // Stage 1 captures the accepted request; stage 2 captures the ALU output.
    always_comb begin
        s1_valid_d    = accept;
        s1_d          = s1_q;
        resp_valid_d  = s1_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_cmp_d    = resp_cmp_q;
        if (accept) begin
            s1_d.id     = grant_id;
            s1_d.opcode = sel_opcode;
            s1_d.a      = sel_a;
            s1_d.b      = sel_b;
        end
        if (s1_valid_q) begin
            resp_id_d     = s1_q.id;
            resp_result_d = alu_result;
            resp_cmp_d    = alu_cmp;
        end
    end

    // All state registers; reset drops any in-flight work outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_cmp_q    <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            s1_valid_q    <= s1_valid_d;
            s1_q          <= s1_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_cmp_q    <= resp_cmp_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_cmp    = resp_cmp_q;
    assign busy        = (|pending_q) | s1_valid_q | resp_valid_q;

endmodule

`default_nettype wire
